// File: rtl/otter_fetch_pkg.sv
// Shared types and constants for the OTTER program counter and instruction fetch.
package otter_fetch_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        VALID = 3'd3,
        EXEC  = 3'd4
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/pc_fetch.sv
// OTTER PC register and one-outstanding-request instruction fetch sequencer.
// Optional macro FETCH_MISALIGN_TRAP_EN: misaligned PC loads raise ir_fault instead of fetching.
module pc_fetch
    import otter_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_din,
    input  logic        pc_we,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic        ir_fault
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  addr_q, addr_d;
    logic [31:0]  ir_q, ir_d;
    logic         drop_q, drop_d;
    logic         fault_q, fault_d;
    logic         start_fetch;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        addr_d      = addr_q;
        ir_d        = ir_q;
        drop_d      = drop_q;
        fault_d     = fault_q;
        start_fetch = 1'b0;

        if (pc_we) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            pc_d = pc_din;
`else
            pc_d = pc_din & 32'hFFFF_FFFC;
`endif
        end

        case (state_q)
            IDLE:  start_fetch = 1'b1;
            REQ: begin
                // The in-flight request keeps its address; its response is marked stale.
                if (pc_we) drop_d = 1'b1;
                if (imem_gnt) state_d = WAIT;
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (drop_q || pc_we) begin
                        drop_d      = 1'b0;
                        start_fetch = 1'b1;
                    end else begin
                        ir_d    = imem_rdata;
                        state_d = VALID;
                    end
                end else if (pc_we) begin
                    drop_d = 1'b1;
                end
            end
            VALID: begin
                if (pc_we)         start_fetch = 1'b1;
                else if (ir_ready) state_d     = EXEC;
            end
            EXEC:    if (pc_we) start_fetch = 1'b1;
            default: state_d = IDLE;
        endcase

        // Begin a fetch from the PC value being committed this cycle.
        if (start_fetch) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            if (pc_d[1:0] != 2'b00) begin
                state_d = VALID;
                ir_d    = NOP_INSTR;
                fault_d = 1'b1;
            end else
`endif
            begin
                state_d = REQ;
                addr_d  = pc_d;
            end
        end

        if (state_d != VALID) fault_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_VECTOR;
            addr_q  <= RESET_VECTOR;
            ir_q    <= NOP_INSTR;
            drop_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            ir_q    <= ir_d;
            drop_q  <= drop_d;
            fault_q <= fault_d;
        end
    end

    assign pc        = pc_q;
    assign pc_plus4  = pc_q + PC_STEP;
    assign imem_req  = (state_q == REQ);
    assign imem_addr = addr_q;
    assign ir        = ir_q;
    assign ir_valid  = (state_q == VALID);
    assign ir_fault  = fault_q;

endmodule
